// File: rtl/arrow_scroller.sv
// rtl/arrow_scroller.sv - arrow queue, scroller and hit judge feeding the sprite renderer
module arrow_scroller #(
    parameter int DEPTH      = 8,
    parameter int LANE_X0    = 400,
    parameter int LANE_PITCH = 48,
    parameter int SPAWN_Y    = 688,
    parameter int TARGET_Y   = 64,
    parameter int SPEED      = 4,
    parameter int WINDOW     = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          frame_in,
    input  logic          spawn_valid_in,
    input  logic [1:0]    spawn_dir_in,
    output logic          spawn_ready_out,
    input  logic          hit_valid_in,
    input  logic [1:0]    hit_dir_in,
    input  logic [AW-1:0] rd_slot_in,
    output logic          rd_valid_out,
    output logic [10:0]   rd_x_out,
    output logic [9:0]    rd_y_out,
    output logic [1:0]    rd_rotate_out,
    output logic          rd_next_out,
    output logic          hit_out,
    output logic          miss_out,
    output logic [AW:0]   count_out
);

    typedef enum logic [1:0] {IDLE, SCROLL, CHECK} state_t;

    state_t        state, state_nxt;
    logic [1:0]    dir_mem [DEPTH];
    logic [9:0]    y_mem   [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic          pend_valid;
    logic [1:0]    pend_dir;

    logic          push, pop, hit_nxt, miss_nxt, pend_set, pend_clr, judge;
    logic [1:0]    judge_dir;
    logic [1:0]    head_dir;
    logic [10:0]   head_y_w;
    logic          in_window, passed;
    logic [AW-1:0] rd_idx;
    logic          rd_ok;
    logic [1:0]    rd_dir;

    assign head_dir  = dir_mem[head];
    assign head_y_w  = {1'b0, y_mem[head]};
    assign in_window = (head_y_w + 11'(WINDOW) >= 11'(TARGET_Y)) &&
                       (head_y_w <= 11'(TARGET_Y + WINDOW));
    assign passed    = (head_y_w + 11'(WINDOW)) < 11'(TARGET_Y);

    assign spawn_ready_out = (state == IDLE) && (count < (AW+1)'(DEPTH));
    assign count_out       = count;

    assign rd_idx = head + rd_slot_in;
    assign rd_ok  = {1'b0, rd_slot_in} < count;
    assign rd_dir = dir_mem[rd_idx];

    // Next state, queue push/pop and hit/miss judgment
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        hit_nxt   = 1'b0;
        miss_nxt  = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        judge     = 1'b0;
        judge_dir = hit_dir_in;
        case (state)
            IDLE: begin
                if (frame_in)
                    state_nxt = SCROLL;
                push = spawn_valid_in && spawn_ready_out;
                // A press held over from SCROLL/CHECK takes priority over a live one
                judge     = pend_valid || hit_valid_in;
                judge_dir = pend_valid ? pend_dir : hit_dir_in;
                pend_clr  = pend_valid;
                if (judge && count != '0) begin
                    if (head_dir == judge_dir && in_window) begin
                        pop     = 1'b1;
                        hit_nxt = 1'b1;
                    end else begin
                        miss_nxt = 1'b1;
                    end
                end
            end
            SCROLL: begin
                state_nxt = CHECK;
                pend_set  = hit_valid_in && !pend_valid;
            end
            CHECK: begin
                state_nxt = IDLE;
                pend_set  = hit_valid_in && !pend_valid;
                if (count != '0 && passed) begin
                    pop      = 1'b1;
                    miss_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers: state, pointers, count, pending press, pulses
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            pend_valid <= 1'b0;
            pend_dir   <= 2'd0;
            hit_out    <= 1'b0;
            miss_out   <= 1'b0;
        end else begin
            state    <= state_nxt;
            hit_out  <= hit_nxt;
            miss_out <= miss_nxt;
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_dir   <= hit_dir_in;
            end else if (pend_clr) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Entry storage; stale entries also scroll, which is harmless since reads gate on count
    always_ff @(posedge clk_in) begin
        if (state == SCROLL) begin
            for (int i = 0; i < DEPTH; i++)
                y_mem[i] <= y_mem[i] - 10'(SPEED);
        end
        if (push) begin
            dir_mem[tail] <= spawn_dir_in;
            y_mem[tail]   <= 10'(SPAWN_Y);
        end
    end

    // Registered read port; invalid slots read as all zero
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_valid_out  <= 1'b0;
            rd_x_out      <= '0;
            rd_y_out      <= '0;
            rd_rotate_out <= '0;
            rd_next_out   <= 1'b0;
        end else begin
            rd_valid_out  <= rd_ok;
            rd_x_out      <= rd_ok ? 11'(LANE_X0 + LANE_PITCH * int'(rd_dir)) : 11'd0;
            rd_y_out      <= rd_ok ? y_mem[rd_idx] : 10'd0;
            rd_rotate_out <= rd_ok ? rd_dir : 2'd0;
            rd_next_out   <= rd_ok && (rd_slot_in == '0);
        end
    end

endmodule

// File: tb/tb_arrow_scroller.sv
// tb/tb_arrow_scroller.sv - directed self-checking bench for arrow_scroller
module tb_arrow_scroller;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        frame_in = 1'b0;
    logic        spawn_valid_in = 1'b0;
    logic [1:0]  spawn_dir_in = 2'd0;
    logic        spawn_ready_out;
    logic        hit_valid_in = 1'b0;
    logic [1:0]  hit_dir_in = 2'd0;
    logic [2:0]  rd_slot_in = 3'd0;
    logic        rd_valid_out;
    logic [10:0] rd_x_out;
    logic [9:0]  rd_y_out;
    logic [1:0]  rd_rotate_out;
    logic        rd_next_out;
    logic        hit_out;
    logic        miss_out;
    logic [3:0]  count_out;

    int checks = 0;
    int failures = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    int both_cnt = 0;
    int h0, m0;

    arrow_scroller dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .frame_in        (frame_in),
        .spawn_valid_in  (spawn_valid_in),
        .spawn_dir_in    (spawn_dir_in),
        .spawn_ready_out (spawn_ready_out),
        .hit_valid_in    (hit_valid_in),
        .hit_dir_in      (hit_dir_in),
        .rd_slot_in      (rd_slot_in),
        .rd_valid_out    (rd_valid_out),
        .rd_x_out        (rd_x_out),
        .rd_y_out        (rd_y_out),
        .rd_rotate_out   (rd_rotate_out),
        .rd_next_out     (rd_next_out),
        .hit_out         (hit_out),
        .miss_out        (miss_out),
        .count_out       (count_out)
    );

    always #5 clk_in = ~clk_in;

    // Pulse monitor sampled mid-cycle
    always @(negedge clk_in) begin
        if (hit_out)
            hit_cnt++;
        if (miss_out)
            miss_cnt++;
        if (hit_out && miss_out)
            both_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic spawn(input logic [1:0] d);
        spawn_valid_in = 1'b1;
        spawn_dir_in   = d;
        tick();
        spawn_valid_in = 1'b0;
    endtask

    task automatic do_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_in = 1'b1;
            tick();
            frame_in = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic press(input logic [1:0] d);
        hit_valid_in = 1'b1;
        hit_dir_in   = d;
        tick();
        hit_valid_in = 1'b0;
        tick();
    endtask

    task automatic read_slot(input logic [2:0] s);
        rd_slot_in = s;
        tick();
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_count", int'(count_out), 0);
        check_eq("rst_ready", int'(spawn_ready_out), 1);
        check_eq("rst_rd_valid", int'(rd_valid_out), 0);
        check_eq("rst_hit", int'(hit_out), 0);
        check_eq("rst_miss", int'(miss_out), 0);

        // Press with empty queue is ignored
        h0 = hit_cnt; m0 = miss_cnt;
        press(2'd0);
        tick();
        check_eq("empty_press_pulses", (hit_cnt - h0) + (miss_cnt - m0), 0);

        // Spawn dir=2 and read it back
        spawn(2'd2);
        check_eq("spawn1_count", int'(count_out), 1);
        read_slot(3'd0);
        check_eq("s0_valid", int'(rd_valid_out), 1);
        check_eq("s0_x", int'(rd_x_out), 496);
        check_eq("s0_y", int'(rd_y_out), 688);
        check_eq("s0_rot", int'(rd_rotate_out), 2);
        check_eq("s0_next", int'(rd_next_out), 1);
        read_slot(3'd1);
        check_eq("s1_valid", int'(rd_valid_out), 0);
        check_eq("s1_x", int'(rd_x_out), 0);
        check_eq("s1_y", int'(rd_y_out), 0);
        check_eq("s1_next", int'(rd_next_out), 0);

        // Hit at the edge of the window (y=80)
        do_reset();
        spawn(2'd0);
        do_frames(152);
        read_slot(3'd0);
        check_eq("t2_y", int'(rd_y_out), 80);
        h0 = hit_cnt; m0 = miss_cnt;
        press(2'd0);
        tick();
        check_eq("t2_hit", hit_cnt - h0, 1);
        check_eq("t2_miss", miss_cnt - m0, 0);
        check_eq("t2_count", int'(count_out), 0);

        // Wrong direction miss, then a passed arrow retires
        spawn(2'd1);
        do_frames(160);
        read_slot(3'd0);
        check_eq("t3_y48", int'(rd_y_out), 48);
        check_eq("t3_count_kept", int'(count_out), 1);
        h0 = hit_cnt; m0 = miss_cnt;
        press(2'd3);
        tick();
        check_eq("t3_press_miss", miss_cnt - m0, 1);
        check_eq("t3_press_hit", hit_cnt - h0, 0);
        check_eq("t3_stays", int'(count_out), 1);
        m0 = miss_cnt;
        do_frames(1);
        tick();
        check_eq("t3_retire_miss", miss_cnt - m0, 1);
        check_eq("t3_retire_count", int'(count_out), 0);

        // Fill the queue from a non-zero head, then refill after a hit
        for (int i = 0; i < 8; i++) begin
            spawn_valid_in = 1'b1;
            spawn_dir_in   = 2'(i);
            tick();
        end
        spawn_dir_in = 2'd3;
        check_eq("full_count", int'(count_out), 8);
        check_eq("full_ready", int'(spawn_ready_out), 0);
        do_frames(152);
        check_eq("full_count_held", int'(count_out), 8);
        h0 = hit_cnt;
        hit_valid_in = 1'b1;
        hit_dir_in   = 2'd0;
        tick();
        hit_valid_in = 1'b0;
        check_eq("full_after_pop", int'(count_out), 7);
        tick();
        spawn_valid_in = 1'b0;
        check_eq("full_refill_count", int'(count_out), 8);
        check_eq("full_hit", hit_cnt - h0, 1);
        read_slot(3'd7);
        check_eq("s7_valid", int'(rd_valid_out), 1);
        check_eq("s7_y", int'(rd_y_out), 688);
        check_eq("s7_rot", int'(rd_rotate_out), 3);
        check_eq("s7_x", int'(rd_x_out), 544);
        check_eq("s7_next", int'(rd_next_out), 0);
        read_slot(3'd0);
        check_eq("s0b_x", int'(rd_x_out), 448);
        check_eq("s0b_y", int'(rd_y_out), 80);
        check_eq("s0b_next", int'(rd_next_out), 1);

        // Press during SCROLL is held and judged on post-scroll y; second press dropped
        do_reset();
        spawn(2'd1);
        do_frames(151);
        read_slot(3'd0);
        check_eq("t5_y84", int'(rd_y_out), 84);
        h0 = hit_cnt; m0 = miss_cnt;
        frame_in = 1'b1;
        tick();
        frame_in     = 1'b0;
        hit_valid_in = 1'b1;
        hit_dir_in   = 2'd1;
        tick();
        tick();
        hit_valid_in = 1'b0;
        tick();
        tick();
        tick();
        check_eq("t5_hit", hit_cnt - h0, 1);
        check_eq("t5_miss", miss_cnt - m0, 0);
        check_eq("t5_count", int'(count_out), 0);

        // Reset during SCROLL
        spawn(2'd0);
        spawn(2'd1);
        spawn(2'd2);
        check_eq("t6_count3", int'(count_out), 3);
        h0 = hit_cnt; m0 = miss_cnt;
        frame_in = 1'b1;
        tick();
        frame_in = 1'b0;
        rst_in   = 1'b1;
        tick();
        rst_in = 1'b0;
        check_eq("t6_count", int'(count_out), 0);
        check_eq("t6_rd_valid", int'(rd_valid_out), 0);
        check_eq("t6_ready", int'(spawn_ready_out), 1);
        tick();
        tick();
        check_eq("t6_pulses", (hit_cnt - h0) + (miss_cnt - m0), 0);

        check_eq("hit_miss_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
